riot_core: RTL and testbench

// Parametrised RAM/I-O/timer peripheral for the 6502 bus, successor to the fixed 6530 RRIOT core.
// It provides N configurable parallel ports, a sized scratch RAM and a 6532-style interval timer.
// The timer has an auto-fast-count mode after underflow.
// It sits beside the ROM on the phi2 bus; the top-level chip-select decode drives cs and ram_sel.

---
 rtl/riot_core.sv | 220 ++++++++++++++++++++++
 tb/tb_riot_core.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/riot_core.sv
// riot_core: RAM, parallel ports and an interval timer with fast count after underflow, for the 6502 bus.
// Optional port-0 edge detector enabled by defining EDGE_DETECT_EN.
module riot_core #(
    parameter int NUM_PORTS = 2,
    parameter int PORT_W    = 8,
    parameter int RAM_AW    = 7
) (
    input  logic                        phi2,
    input  logic                        rst,
    input  logic                        cs,
    input  logic                        ram_sel,
    input  logic                        we_n,
    input  logic [RAM_AW-1:0]           A,
    input  logic [7:0]                  DI,
    output logic [7:0]                  DO,
    output logic                        OE,
    input  logic [NUM_PORTS*PORT_W-1:0] PI,
    output logic [NUM_PORTS*PORT_W-1:0] PO,
    output logic [NUM_PORTS*PORT_W-1:0] DDR,
    output logic                        IRQ
);

    localparam int PW = NUM_PORTS * PORT_W;

    logic [7:0]    ram_q [2**RAM_AW];
    logic [7:0]    do_q;
    logic          oe_q;
    logic [PW-1:0] po_q, ddr_q;

    logic [7:0] count_q, count_d;
    logic [9:0] preCount_q, preCount_d;
    logic [1:0] preSel_q, preSel_d;
    logic       fast_q, fast_d;
    logic       timerFlag_q, timerFlag_d;
    logic       timerIen_q, timerIen_d;

    logic edgeFlag, edgeIen;
    logic rd, wr, regRd, regWr, ramWr, portWr;
    logic timerLoad, countRd, flagRd;
    logic tick, underflow;
    logic [7:0] readData;
    logic [PORT_W-1:0] portVal;

    assign rd        = cs & we_n;
    assign wr        = cs & ~we_n;
    assign regRd     = rd & ~ram_sel;
    assign regWr     = wr & ~ram_sel;
    assign ramWr     = wr & ram_sel;
    assign portWr    = regWr & ~A[4];
    assign timerLoad = regWr & A[4] & A[2];
    assign countRd   = regRd & A[4] & ~A[0];
    assign flagRd    = regRd & A[4] & A[0];

    // Prescaler reload value is P-1 so a tick lands exactly P cycles later.
    function automatic logic [9:0] presetOf(input logic [1:0] sel);
        case (sel)
            2'b00:   return 10'd0;
            2'b01:   return 10'd7;
            2'b10:   return 10'd63;
            default: return 10'd1023;
        endcase
    endfunction

    assign tick      = fast_q | (preCount_q == '0);
    assign underflow = tick & (count_q == 8'h00);

    // Order matters: read clears, then a same-cycle underflow re-sets, then a load overrides all.
    always_comb begin
        count_d     = count_q;
        preCount_d  = preCount_q;
        preSel_d    = preSel_q;
        fast_d      = fast_q;
        timerFlag_d = timerFlag_q;
        timerIen_d  = timerIen_q;
        if (tick) begin
            count_d    = count_q - 8'd1;
            preCount_d = presetOf(preSel_q);
        end else begin
            preCount_d = preCount_q - 10'd1;
        end
        if (countRd) begin
            timerFlag_d = 1'b0;
            timerIen_d  = A[3];
            fast_d      = 1'b0;
            preCount_d  = presetOf(preSel_q);
        end
        if (underflow) begin
            timerFlag_d = 1'b1;
            fast_d      = 1'b1;
        end
        if (timerLoad) begin
            count_d     = DI;
            preSel_d    = A[1:0];
            preCount_d  = presetOf(A[1:0]);
            fast_d      = 1'b0;
            timerFlag_d = 1'b0;
            timerIen_d  = A[3];
        end
    end

    always_ff @(posedge phi2) begin
        if (rst) begin
            count_q     <= 8'hFF;
            preCount_q  <= 10'd1023;
            preSel_q    <= 2'b11;
            fast_q      <= 1'b0;
            timerFlag_q <= 1'b0;
            timerIen_q  <= 1'b0;
        end else begin
            count_q     <= count_d;
            preCount_q  <= preCount_d;
            preSel_q    <= preSel_d;
            fast_q      <= fast_d;
            timerFlag_q <= timerFlag_d;
            timerIen_q  <= timerIen_d;
        end
    end

`ifdef EDGE_DETECT_EN
    logic edgeSync_q, edgePrev_q, edgePol_q, edgeIen_q, edgeFlag_q;
    logic edgeSeen, edgeCfgWr;

    assign edgeCfgWr = regWr & A[4] & ~A[2];
    assign edgeSeen  = edgePol_q ? (edgeSync_q & ~edgePrev_q) : (~edgeSync_q & edgePrev_q);

    // A new edge beats a same-cycle flag read so the event is never lost.
    always_ff @(posedge phi2) begin
        if (rst) begin
            edgeSync_q <= 1'b0;
            edgePrev_q <= 1'b0;
            edgePol_q  <= 1'b0;
            edgeIen_q  <= 1'b0;
            edgeFlag_q <= 1'b0;
        end else begin
            edgeSync_q <= PI[PORT_W-1];
            edgePrev_q <= edgeSync_q;
            if (edgeCfgWr) begin
                edgePol_q <= A[0];
                edgeIen_q <= A[1];
            end
            if (edgeSeen)
                edgeFlag_q <= 1'b1;
            else if (flagRd)
                edgeFlag_q <= 1'b0;
        end
    end

    assign edgeFlag = edgeFlag_q;
    assign edgeIen  = edgeIen_q;
`else
    assign edgeFlag = 1'b0;
    assign edgeIen  = 1'b0;
`endif

    always_ff @(posedge phi2) begin
        if (rst) begin
            po_q  <= '0;
            ddr_q <= '0;
        end else if (portWr) begin
            for (int k = 0; k < NUM_PORTS; k++) begin
                if (A[3:1] == 3'(k)) begin
                    if (A[0])
                        ddr_q[k*PORT_W +: PORT_W] <= DI[PORT_W-1:0];
                    else
                        po_q[k*PORT_W +: PORT_W] <= DI[PORT_W-1:0];
                end
            end
        end
    end

    // RAM contents deliberately survive reset.
    always_ff @(posedge phi2) begin
        if (!rst && ramWr)
            ram_q[A] <= DI;
    end

    always_comb begin
        portVal = '0;
        for (int k = 0; k < NUM_PORTS; k++) begin
            if (A[3:1] == 3'(k)) begin
                if (A[0])
                    portVal = ddr_q[k*PORT_W +: PORT_W];
                else
                    portVal = (po_q[k*PORT_W +: PORT_W] & ddr_q[k*PORT_W +: PORT_W])
                            | (PI[k*PORT_W +: PORT_W] & ~ddr_q[k*PORT_W +: PORT_W]);
            end
        end
    end

    always_comb begin
        readData = 8'h00;
        if (ram_sel)
            readData = ram_q[A];
        else if (!A[4])
            readData[PORT_W-1:0] = portVal;
        else if (!A[0])
            readData = count_q;
        else
            readData = {timerFlag_q, edgeFlag, 6'b0};
    end

    always_ff @(posedge phi2) begin
        if (rst) begin
            do_q <= 8'h00;
            oe_q <= 1'b0;
        end else if (rd) begin
            do_q <= readData;
            oe_q <= 1'b1;
        end else begin
            oe_q <= 1'b0;
        end
    end

    assign DO  = do_q;
    assign OE  = oe_q;
    assign PO  = po_q;
    assign DDR = ddr_q;
    assign IRQ = (timerFlag_q & timerIen_q) | (edgeFlag & edgeIen);

endmodule

// File: tb/tb_riot_core.sv
// Directed self-checking bench for riot_core (default parameters); expectations follow EDGE_DETECT_EN.
module tb_riot_core;

    logic        phi2 = 1'b0;
    logic        rst = 1'b1;
    logic        cs = 1'b0;
    logic        ram_sel = 1'b0;
    logic        we_n = 1'b1;
    logic [6:0]  A = '0;
    logic [7:0]  DI = '0;
    logic [7:0]  DO;
    logic        OE;
    logic [15:0] PI = '0;
    logic [15:0] PO;
    logic [15:0] DDR;
    logic        IRQ;

    int checks = 0;
    int errors = 0;

    riot_core #(.NUM_PORTS(2), .PORT_W(8), .RAM_AW(7)) dut (
        .phi2(phi2), .rst(rst), .cs(cs), .ram_sel(ram_sel), .we_n(we_n),
        .A(A), .DI(DI), .DO(DO), .OE(OE), .PI(PI), .PO(PO), .DDR(DDR), .IRQ(IRQ)
    );

    always #5 phi2 = ~phi2;

`ifdef EDGE_DETECT_EN
    localparam logic       EDGE_ON = 1'b1;
`else
    localparam logic       EDGE_ON = 1'b0;
`endif

    task automatic checkOutput(input string tag, input logic [15:0] actual, input logic [15:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h, expected %h", tag, actual, expected);
        end
    endtask

    // One bus cycle: drive at the falling edge, return at the next falling edge with cs released.
    task automatic applyStimulus(input logic ramSel, input logic write, input logic [6:0] addr,
                                 input logic [7:0] data);
        cs = 1'b1;
        ram_sel = ramSel;
        we_n = ~write;
        A = addr;
        DI = data;
        @(posedge phi2);
        @(negedge phi2);
        cs = 1'b0;
        we_n = 1'b1;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge phi2);
            @(negedge phi2);
        end
    endtask

    initial begin
        repeat (2) @(posedge phi2);
        @(negedge phi2);
        checkOutput("rst_do", {8'h0, DO}, 16'h0000);
        checkOutput("rst_oe", {15'h0, OE}, 16'h0000);
        checkOutput("rst_po", PO, 16'h0000);
        checkOutput("rst_ddr", DDR, 16'h0000);
        checkOutput("rst_irq", {15'h0, IRQ}, 16'h0000);
        checkOutput("rst_count", {8'h0, dut.count_q}, 16'h00FF);
        rst = 1'b0;

        applyStimulus(1'b1, 1'b1, 7'h7F, 8'hA5);
        applyStimulus(1'b1, 1'b1, 7'h00, 8'h3C);
        applyStimulus(1'b1, 1'b0, 7'h7F, 8'h00);
        checkOutput("ram_rd7f", {8'h0, DO}, 16'h00A5);
        checkOutput("ram_oe", {15'h0, OE}, 16'h0001);
        idle(1);
        checkOutput("ram_oe_drop", {15'h0, OE}, 16'h0000);
        applyStimulus(1'b1, 1'b0, 7'h00, 8'h00);
        checkOutput("ram_rd00", {8'h0, DO}, 16'h003C);

        PI = 16'h555A;
        applyStimulus(1'b0, 1'b1, 7'h01, 8'hF0);
        applyStimulus(1'b0, 1'b1, 7'h00, 8'h3C);
        applyStimulus(1'b0, 1'b1, 7'h03, 8'h0F);
        applyStimulus(1'b0, 1'b1, 7'h02, 8'hAA);
        applyStimulus(1'b0, 1'b0, 7'h00, 8'h00);
        checkOutput("port0_rd", {8'h0, DO}, 16'h003A);
        applyStimulus(1'b0, 1'b0, 7'h01, 8'h00);
        checkOutput("ddr0_rd", {8'h0, DO}, 16'h00F0);
        applyStimulus(1'b0, 1'b0, 7'h02, 8'h00);
        checkOutput("port1_rd", {8'h0, DO}, 16'h005A);
        applyStimulus(1'b0, 1'b1, 7'h0A, 8'hFF);
        applyStimulus(1'b0, 1'b0, 7'h0A, 8'h00);
        checkOutput("port5_rd", {8'h0, DO}, 16'h0000);
        checkOutput("po_out", PO, 16'hAA3C);
        checkOutput("ddr_out", DDR, 16'h0FF0);

        // Divide-by-8 load of 2 with interrupt enabled.
        applyStimulus(1'b0, 1'b1, 7'h1D, 8'h02);
        idle(7);
        checkOutput("t8_c7", {8'h0, dut.count_q}, 16'h0002);
        idle(1);
        checkOutput("t8_c8", {8'h0, dut.count_q}, 16'h0001);
        idle(8);
        checkOutput("t8_c16", {8'h0, dut.count_q}, 16'h0000);
        idle(7);
        checkOutput("t8_irq23", {15'h0, IRQ}, 16'h0000);
        idle(1);
        checkOutput("t8_irq24", {15'h0, IRQ}, 16'h0001);
        checkOutput("t8_c24", {8'h0, dut.count_q}, 16'h00FF);
        idle(1);
        checkOutput("t8_c25", {8'h0, dut.count_q}, 16'h00FE);
        applyStimulus(1'b0, 1'b0, 7'h11, 8'h00);
        checkOutput("t8_flagrd", {8'h0, DO}, 16'h0080);
        applyStimulus(1'b0, 1'b0, 7'h18, 8'h00);
        checkOutput("t8_countrd", {8'h0, DO}, 16'h00FD);
        checkOutput("t8_irqclr", {15'h0, IRQ}, 16'h0000);
        idle(7);
        checkOutput("t8_slow7", {8'h0, dut.count_q}, 16'h00FC);
        idle(1);
        checkOutput("t8_slow8", {8'h0, dut.count_q}, 16'h00FB);

        // Divide-by-1 load of 3: underflow tick falls on the fourth edge, where the reload lands.
        applyStimulus(1'b0, 1'b1, 7'h1C, 8'h03);
        idle(3);
        applyStimulus(1'b0, 1'b1, 7'h1C, 8'h10);
        checkOutput("coll_flag", {15'h0, dut.timerFlag_q}, 16'h0000);
        checkOutput("coll_irq", {15'h0, IRQ}, 16'h0000);
        checkOutput("coll_count", {8'h0, dut.count_q}, 16'h0010);
        idle(1);
        checkOutput("coll_next", {8'h0, dut.count_q}, 16'h000F);
        applyStimulus(1'b0, 1'b1, 7'h17, 8'hFF);

        applyStimulus(1'b0, 1'b1, 7'h13, 8'h00);
        PI[7] = 1'b1;
        idle(2);
        checkOutput("edge_irq", {15'h0, IRQ}, {15'h0, EDGE_ON});
        applyStimulus(1'b0, 1'b0, 7'h11, 8'h00);
        checkOutput("edge_flagrd", {8'h0, DO}, EDGE_ON ? 16'h0040 : 16'h0000);
        checkOutput("edge_irqclr", {15'h0, IRQ}, 16'h0000);

        // Falling edge detected on the same edge as a flag read: the set must survive.
        applyStimulus(1'b0, 1'b1, 7'h12, 8'h00);
        PI[7] = 1'b0;
        idle(1);
        applyStimulus(1'b0, 1'b0, 7'h11, 8'h00);
        checkOutput("edge_coll_rd", {8'h0, DO}, 16'h0000);
        checkOutput("edge_coll_irq", {15'h0, IRQ}, {15'h0, EDGE_ON});
        applyStimulus(1'b0, 1'b0, 7'h11, 8'h00);
        checkOutput("edge_coll_rd2", {8'h0, DO}, EDGE_ON ? 16'h0040 : 16'h0000);

        applyStimulus(1'b0, 1'b1, 7'h1C, 8'h05);
        idle(6);
        checkOutput("pre_rst_irq", {15'h0, IRQ}, 16'h0001);
        rst = 1'b1;
        applyStimulus(1'b1, 1'b0, 7'h7F, 8'h00);
        rst = 1'b0;
        checkOutput("mid_rst_count", {8'h0, dut.count_q}, 16'h00FF);
        checkOutput("mid_rst_irq", {15'h0, IRQ}, 16'h0000);
        checkOutput("mid_rst_ddr", DDR, 16'h0000);
        checkOutput("mid_rst_po", PO, 16'h0000);
        checkOutput("mid_rst_oe", {15'h0, OE}, 16'h0000);
        checkOutput("mid_rst_do", {8'h0, DO}, 16'h0000);
        applyStimulus(1'b1, 1'b0, 7'h7F, 8'h00);
        checkOutput("ram_kept", {8'h0, DO}, 16'h00A5);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
